// File: rtl/dmem_responder_if.sv
// Request/response bus between the L2 side and the data-memory responder.
// The L2 side drives requests and response acceptance; the responder drives the rest.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [6:0]  opcode_in;
   logic [31:0] addr;
   logic [31:0] data_from_L2;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] data_from_dmem;
   logic        rsp_err;

   modport master (
      output req_valid, opcode_in, addr, data_from_L2, rsp_ready,
      input  req_ready, rsp_valid, data_from_dmem, rsp_err
   );

   modport slave (
      input  req_valid, opcode_in, addr, data_from_L2, rsp_ready,
      output req_ready, rsp_valid, data_from_dmem, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store, waits LATENCY
// cycles, performs the access and holds the response until the L2 side takes it.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 4
) (
   input logic             clk,
   input logic             reset,
   dmem_responder_if.slave bus
);
   localparam int unsigned AW      = $clog2(DEPTH_WORDS);
   localparam logic [6:0]  OpLoad  = 7'b0000011;
   localparam logic [6:0]  OpStore = 7'b0100011;

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [6:0]    op_q, op_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic [31:0]   mem_q [DEPTH_WORDS];
   logic          mem_we;
   logic [AW-1:0] widx;
   logic          req_err;

   assign widx               = addr_q[AW+1:2];
   assign bus.req_ready      = (state_q == StIdle);
   assign bus.rsp_valid      = (state_q == StResp);
   assign bus.data_from_dmem = rdata_q;
   assign bus.rsp_err        = err_q;

   always_comb begin
      req_err = 1'b0;
      if (op_q != OpLoad && op_q != OpStore) begin
         req_err = 1'b1;
      end else if (addr_q[1:0] != 2'b00) begin
         req_err = 1'b1;
      end else if (addr_q[31:2] >= 30'(DEPTH_WORDS)) begin
         req_err = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      mem_we  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               op_d    = bus.opcode_in;
               addr_d  = bus.addr;
               wdata_d = bus.data_from_L2;
               cnt_d   = 4'(LATENCY - 1);
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (cnt_q == 4'd0) begin
               // Access happens on the edge that enters StResp.
               state_d = StResp;
               err_d   = req_err;
               rdata_d = '0;
               if (!req_err && op_q == OpStore) mem_we  = 1'b1;
               if (!req_err && op_q == OpLoad)  rdata_d = mem_q[widx];
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: begin
            if (bus.rsp_ready) begin
               state_d = StIdle;
               err_d   = 1'b0;
               rdata_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH_WORDS); i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[widx] <= wdata_q;
      end
   end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in storage (power of two, >=2).
REQ-002 Parameter LATENCY, default 4, access latency in cycles from request accept to response valid (1..15).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  L2-side request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 opcode_in  input  7  request type: 7'b0000011 load, 7'b0100011 store; all other values illegal.
REQ-008 addr  input  32  byte address of request.
REQ-009 data_from_L2  input  32  store data.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  L2 accepts response this cycle.
REQ-012 data_from_dmem  output  32  load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  request was illegal (bad opcode, addr[1:0]!=0, or word index >= DEPTH_WORDS).

Function
REQ-014 Request handshake completes in a cycle where req_valid && req_ready; opcode_in, addr, data_from_L2 captured into request registers on that edge.
REQ-015 FSM states: IDLE, BUSY, RESP; req_ready = 1 only in IDLE.
REQ-016 IDLE -> BUSY on accepted request; latency counter loaded with LATENCY-1.
REQ-017 BUSY: counter decrements each cycle; at counter==0 transition to RESP on next edge, so rsp_valid first asserts exactly LATENCY cycles after the accept edge.
REQ-018 Store: memory word written on BUSY->RESP edge when request legal; illegal store leaves memory unchanged.
REQ-019 Load: data_from_dmem registered on BUSY->RESP edge from word addr[log2(DEPTH_WORDS)+1:2]; a store and load to the same word issued back-to-back returns the stored value.
REQ-020 rsp_err, data_from_dmem held stable while rsp_valid=1 and rsp_ready=0.
REQ-021 RESP -> IDLE on rsp_valid && rsp_ready; rsp_valid deasserts on that edge; req_ready asserts the same edge, earliest next accept one cycle after response handshake.
REQ-022 Inputs req_valid/opcode/addr/data changing in BUSY or RESP ignored; no request queuing.
REQ-023 rsp_err=1 forces data_from_dmem=0; error precedence: bad opcode, then misalignment, then range.
REQ-024 Counter width 4 bits; no wrap-around occurs for legal LATENCY.

Reset
REQ-025 reset low immediately (asynchronously) forces FSM to IDLE, counter 0, req_ready=1 after release, rsp_valid=0, rsp_err=0, data_from_dmem=0.
REQ-026 Memory contents are cleared to 0 on reset.
REQ-027 Reset asserted mid-BUSY aborts the request: a pending store is not written; no response is produced after release.
REQ-028 First request accepted on first rising edge with reset high and req_valid=1.

Verification
REQ-029 Store 0xDEADBEEF to 0x10, rsp_ready=1 -> rsp_valid exactly 4 cycles after accept, rsp_err=0, data=0; then load 0x10 -> data_from_dmem=0xDEADBEEF.
REQ-030 Load 0x10 with rsp_ready=0 for 3 cycles -> rsp_valid, data held 3 cycles, req_ready=0 throughout, accept next request one cycle after handshake.
REQ-031 Load 0x13 (misaligned), opcode 7'b0110011, and addr 0x1000 (DEPTH 1024) -> each rsp_err=1, data 0; memory unchanged on subsequent loads.
REQ-032 Store 0x55 to 0x20, assert reset during BUSY cycle 2 -> outputs zero immediately, after release load 0x20 returns 0, no stray rsp_valid.
REQ-033 LATENCY=1 build: back-to-back store/load to 0x0 with rsp_ready tied 1 -> response one cycle after each accept, load returns stored value.
REQ-034 req_valid toggled with random addr/data during BUSY/RESP -> response matches only the accepted request.
